lsu: RTL and testbench

Per-thread load/store unit sitting directly downstream of the ALU in each thread's execute path. It consumes the registered ALU result as a byte address, performs one word-addressed data-memory transaction per memory instruction through a valid/ready handshake, and returns aligned, sign- or zero-extended load data for register writeback. It reports its progress to the warp scheduler through `lsu_state`.

---
 rtl/common_pkg.sv | 32 +++
 rtl/lsu_align.sv | 40 ++++
 rtl/lsu.sv | 112 +++++++++++
 tb/tb_lsu.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared widths, warp/LSU state encodings and memory size codes
package common_pkg;

    localparam int DATA_MEM_ADDR_BITS = 10;

    typedef logic [31:0]                   data_t;
    typedef logic [DATA_MEM_ADDR_BITS-1:0] data_mem_addr_t;

    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;

    typedef enum logic [1:0] {
        LSU_IDLE       = 2'd0,
        LSU_REQUESTING = 2'd1,
        LSU_DONE       = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane placement, strobes, load extension and alignment check
import common_pkg::*;

module lsu_align (
    input  logic [1:0] size,
    input  logic [1:0] offset,
    input  logic       usign,
    input  data_t      store_raw,
    input  data_t      load_raw,
    output data_t      store_data,
    output logic [3:0] strb,
    output data_t      load_data,
    output logic       misaligned
);

    logic [15:0] load_low;

    always_comb begin
        store_data = store_raw << {offset, 3'b000};
        load_low   = 16'(load_raw >> {offset, 3'b000});
        strb       = 4'b1111;
        load_data  = load_raw;
        misaligned = (offset != 2'd0);
        case (size)
            MEM_BYTE: begin
                strb       = 4'b0001 << offset;
                load_data  = {{24{~usign & load_low[7]}}, load_low[7:0]};
                misaligned = 1'b0;
            end
            MEM_HALF: begin
                strb       = 4'b0011 << offset;
                load_data  = {{16{~usign & load_low[15]}}, load_low};
                misaligned = offset[0];
            end
            // word and the reserved code both behave as a full word
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - per-thread load/store unit with valid/ready data-memory handshake
import common_pkg::*;

module lsu (
    input  logic           clk,
    input  logic           reset,
    input  warp_state_t    warp_state,
    input  logic           MemRead,
    input  logic           MemWrite,
    input  logic [1:0]     MemSize,
    input  logic           Usign,
    input  data_t          alu_out,
    input  data_t          rs2,
    output logic           mem_read_valid,
    output data_mem_addr_t mem_read_addr,
    input  logic           mem_read_ready,
    input  data_t          mem_read_data,
    output logic           mem_write_valid,
    output data_mem_addr_t mem_write_addr,
    output data_t          mem_write_data,
    output logic [3:0]     mem_write_strb,
    input  logic           mem_write_ready,
    output data_t          lsu_out,
    output lsu_state_t     lsu_state,
    output logic           lsu_misaligned
);

    lsu_state_t     state, state_next;
    data_mem_addr_t addr_q;
    logic [1:0]     off_q, size_q;
    logic           usign_q, is_read_q;
    data_t          wdata_q;
    logic [3:0]     strb_q;

    logic [1:0]     sel_size, sel_off;
    logic           sel_usign;
    data_t          st_data, ld_data;
    logic [3:0]     st_strb;
    logic           mis;
    logic           start, completes;
    logic           unused_alu_bits;

    assign unused_alu_bits = ^alu_out[31:DATA_MEM_ADDR_BITS+2];

    // live request fields feed the aligner while idle; latched fields afterwards for load extension
    assign sel_size  = (state == LSU_IDLE) ? MemSize     : size_q;
    assign sel_off   = (state == LSU_IDLE) ? alu_out[1:0] : off_q;
    assign sel_usign = (state == LSU_IDLE) ? Usign       : usign_q;

    lsu_align u_align (
        .size       (sel_size),
        .offset     (sel_off),
        .usign      (sel_usign),
        .store_raw  (rs2),
        .load_raw   (mem_read_data),
        .store_data (st_data),
        .strb       (st_strb),
        .load_data  (ld_data),
        .misaligned (mis)
    );

    assign start     = (state == LSU_IDLE) && (warp_state == WARP_REQUEST) && (MemRead || MemWrite);
    assign completes = (state == LSU_REQUESTING) && (is_read_q ? mem_read_ready : mem_write_ready);

    always_comb begin
        state_next = state;
        case (state)
            LSU_IDLE:       if (start) state_next = mis ? LSU_DONE : LSU_REQUESTING;
            LSU_REQUESTING: if (completes) state_next = LSU_DONE;
            LSU_DONE:       if (warp_state == WARP_UPDATE) state_next = LSU_IDLE;
            default:        state_next = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= LSU_IDLE;
            addr_q         <= '0;
            off_q          <= '0;
            size_q         <= '0;
            usign_q        <= 1'b0;
            is_read_q      <= 1'b0;
            wdata_q        <= '0;
            strb_q         <= '0;
            lsu_out        <= '0;
            lsu_misaligned <= 1'b0;
        end else begin
            state <= state_next;
            if (start) begin
                addr_q         <= alu_out[DATA_MEM_ADDR_BITS+1:2];
                off_q          <= alu_out[1:0];
                size_q         <= MemSize;
                usign_q        <= Usign;
                is_read_q      <= MemRead;
                wdata_q        <= st_data;
                strb_q         <= st_strb;
                lsu_misaligned <= mis;
            end
            if (completes && is_read_q)
                lsu_out <= ld_data;
        end
    end

    assign mem_read_valid  = (state == LSU_REQUESTING) && is_read_q;
    assign mem_write_valid = (state == LSU_REQUESTING) && !is_read_q;
    assign mem_read_addr   = addr_q;
    assign mem_write_addr  = addr_q;
    assign mem_write_data  = wdata_q;
    assign mem_write_strb  = strb_q;
    assign lsu_state       = state;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized self-checking bench for lsu against a behavioural model
import common_pkg::*;

module tb_lsu;

    logic           clk;
    logic           reset;
    warp_state_t    warp_state;
    logic           MemRead, MemWrite, Usign;
    logic [1:0]     MemSize;
    data_t          alu_out, rs2;
    logic           mem_read_valid, mem_read_ready;
    data_mem_addr_t mem_read_addr;
    data_t          mem_read_data;
    logic           mem_write_valid, mem_write_ready;
    data_mem_addr_t mem_write_addr;
    data_t          mem_write_data;
    logic [3:0]     mem_write_strb;
    data_t          lsu_out;
    lsu_state_t     lsu_state;
    logic           lsu_misaligned;

    int    checks;
    int    errors;
    data_t model_out;

    lsu dut (
        .clk             (clk),
        .reset           (reset),
        .warp_state      (warp_state),
        .MemRead         (MemRead),
        .MemWrite        (MemWrite),
        .MemSize         (MemSize),
        .Usign           (Usign),
        .alu_out         (alu_out),
        .rs2             (rs2),
        .mem_read_valid  (mem_read_valid),
        .mem_read_addr   (mem_read_addr),
        .mem_read_ready  (mem_read_ready),
        .mem_read_data   (mem_read_data),
        .mem_write_valid (mem_write_valid),
        .mem_write_addr  (mem_write_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_strb  (mem_write_strb),
        .mem_write_ready (mem_write_ready),
        .lsu_out         (lsu_out),
        .lsu_state       (lsu_state),
        .lsu_misaligned  (lsu_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input int size, input logic us, input int off, input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * off);
        if (size == 0) begin
            v = v % 256;
            if (!us && v >= 128) v = v + 32'hFFFFFF00;
        end else if (size == 1) begin
            v = v % 65536;
            if (!us && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    task automatic run_op(input logic rd, input logic wr, input logic [1:0] size, input logic us,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                          input int stall);
        int          off, sz, edges;
        logic        mis;
        logic [3:0]  strb_e;
        logic [31:0] data_e, mask, waddr_e;
        off     = int'(addr[1:0]);
        sz      = int'(size);
        waddr_e = (addr >> 2) % (1 << DATA_MEM_ADDR_BITS);
        mis     = (sz == 1) ? (off % 2 == 1) : (sz >= 2) ? (off != 0) : 1'b0;
        strb_e  = (sz == 0) ? 4'(1 << off) : (sz == 1) ? 4'(3 << off) : 4'hF;
        mask    = '0;
        data_e  = '0;
        for (int i = 0; i < 4; i++) begin
            if (strb_e[i]) begin
                mask[8*i +: 8]   = 8'hFF;
                data_e[8*i +: 8] = wd[8*(i-off) +: 8];
            end
        end

        @(negedge clk);
        warp_state      = WARP_REQUEST;
        MemRead         = rd;
        MemWrite        = wr;
        MemSize         = size;
        Usign           = us;
        alu_out         = addr;
        rs2             = wd;
        mem_read_data   = rdata;
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        @(negedge clk);
        edges = 1;
        // scramble the request inputs so any failure to latch shows up
        warp_state = WARP_EXECUTE;
        alu_out    = $urandom;
        rs2        = $urandom;
        MemSize    = 2'($urandom_range(0, 3));
        Usign      = 1'($urandom_range(0, 1));

        if (!rd && !wr) begin
            check("noop_state", lsu_state, LSU_IDLE);
            check("noop_valids", {mem_read_valid, mem_write_valid}, 2'b00);
            return;
        end

        while (lsu_state == LSU_REQUESTING && edges < 40) begin
            if (rd) begin
                check("rd_valid", {mem_read_valid, mem_write_valid}, 2'b10);
                check("rd_addr", mem_read_addr, waddr_e);
                mem_read_ready = (edges > stall);
            end else begin
                check("wr_valid", {mem_read_valid, mem_write_valid}, 2'b01);
                check("wr_addr", mem_write_addr, waddr_e);
                check("wr_data", mem_write_data & mask, data_e);
                check("wr_strb", mem_write_strb, strb_e);
                mem_write_ready = (edges > stall);
            end
            @(negedge clk);
            edges++;
        end
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;

        if (rd && !mis) model_out = ref_load(sz, us, off, rdata);
        check("done_edge", edges, mis ? 1 : 2 + stall);
        check("done_state", lsu_state, LSU_DONE);
        check("done_valids", {mem_read_valid, mem_write_valid}, 2'b00);
        check("lsu_out", lsu_out, model_out);
        check("misaligned", lsu_misaligned, mis);

        @(negedge clk);
        check("done_hold", lsu_state, LSU_DONE);
        warp_state = WARP_UPDATE;
        @(negedge clk);
        warp_state = WARP_IDLE;
        check("update_idle", lsu_state, LSU_IDLE);
        check("mis_sticky", lsu_misaligned, mis);
        check("out_hold", lsu_out, model_out);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        model_out       = '0;
        reset           = 1'b0;
        warp_state      = WARP_IDLE;
        MemRead         = 1'b0;
        MemWrite        = 1'b0;
        MemSize         = 2'd0;
        Usign           = 1'b0;
        alu_out         = '0;
        rs2             = '0;
        mem_read_ready  = 1'b0;
        mem_read_data   = '0;
        mem_write_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", lsu_state, LSU_IDLE);
        check("rst_valids", {mem_read_valid, mem_write_valid}, 2'b00);
        check("rst_out", lsu_out, 32'h0);
        check("rst_addr", {mem_read_addr, mem_write_addr}, '0);
        check("rst_wdata", mem_write_data, 32'h0);
        check("rst_strb", mem_write_strb, 4'h0);
        check("rst_mis", lsu_misaligned, 1'b0);
        reset = 1'b1;

        run_op(1, 0, 2'd2, 0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
        run_op(1, 0, 2'd0, 0, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);
        run_op(1, 0, 2'd0, 1, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1);
        run_op(0, 1, 2'd1, 0, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 3);
        check("half_data", mem_write_data, 32'hABCD_0000);
        run_op(1, 0, 2'd2, 0, 32'h0000_0101, 32'h0, 32'h1234_5678, 0);
        run_op(0, 0, 2'd2, 0, 32'h0000_0100, 32'h0, 32'h0, 0);
        run_op(1, 1, 2'd1, 1, 32'h0000_0306, 32'h5555_5555, 32'hF00D_8001, 2);

        // reset while a read is stalled
        @(negedge clk);
        warp_state     = WARP_REQUEST;
        MemRead        = 1'b1;
        MemWrite       = 1'b0;
        MemSize        = 2'd2;
        alu_out        = 32'h0000_0044;
        mem_read_ready = 1'b0;
        @(negedge clk);
        warp_state = WARP_EXECUTE;
        check("rstop_valid", mem_read_valid, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        model_out = '0;
        check("rstop_state", lsu_state, LSU_IDLE);
        check("rstop_valid0", mem_read_valid, 1'b0);
        check("rstop_out", lsu_out, 32'h0);
        reset      = 1'b1;
        warp_state = WARP_IDLE;
        run_op(1, 0, 2'd2, 0, 32'h0000_0048, 32'h0, 32'hCAFE_F00D, 0);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] ops;
            ops = 2'($urandom_range(0, 3));
            run_op(ops[0], ops[1], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
